// File: rtl/rs_error_corrector.sv
// RS(31,27) final stage: XORs CSEE error magnitudes onto received symbols,
// counts corrections per codeword and flags decode failure against the
// error-locator degree.
//
// Ports:
//   clock, reset (async active-low)
//   start        - codeword begins next cycle, samples lambda_deg
//   lambda_deg   - error-locator degree from key-equation solver
//   hold         - stall, no symbol consumed this cycle
//   sym_in       - received symbol
//   err_loc      - CSEE root-found flag
//   err_val      - CSEE error magnitude
//   dataout      - corrected symbol (registered)
//   out_valid    - dataout valid
//   out_last     - marks symbol N-1
//   done         - one-cycle status pulse
//   decode_fail  - status, held until next accepted start
//   err_count    - corrections in last codeword (saturating)
//   busy         - high in LOAD and CORRECT
//
// Optional: define RS_CORR_STATS_EN to add cw_count / fail_count outputs.

module rs_error_corrector #(
    parameter int SYM_W = 5,
    parameter int N     = 31,
    parameter int T     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       lambda_deg,
    input  logic             hold,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             err_loc,
    input  logic [SYM_W-1:0] err_val,
    output logic [SYM_W-1:0] dataout,
    output logic             out_valid,
    output logic             out_last,
    output logic             done,
    output logic             decode_fail,
    output logic [2:0]       err_count,
    output logic             busy
`ifdef RS_CORR_STATS_EN
    ,
    output logic [15:0]      cw_count,
    output logic [15:0]      fail_count
`endif
);

    localparam int         CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [2:0] T_L   = 3'(T);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CORRECT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       deg_r;
    logic             fail_now;

    // err_count is already final when the FSM sits in DONE.
    assign fail_now = (deg_r > T_L) || (err_count != deg_r);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            deg_r       <= '0;
            dataout     <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            decode_fail <= 1'b0;
            err_count   <= '0;
            busy        <= 1'b0;
`ifdef RS_CORR_STATS_EN
            cw_count    <= '0;
            fail_count  <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    if (start) begin
                        deg_r       <= lambda_deg;
                        err_count   <= '0;
                        decode_fail <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    // Status from a back-to-back predecessor stays visible
                    // during its done pulse (this cycle), then clears.
                    counter     <= '0;
                    err_count   <= '0;
                    decode_fail <= 1'b0;
                    state       <= CORRECT;
                end
                CORRECT: begin
                    if (!hold) begin
                        dataout   <= sym_in ^ (err_loc ? err_val : '0);
                        out_valid <= 1'b1;
                        if (err_loc && err_count != 3'd7)
                            err_count <= err_count + 3'd1;
                        if (counter == LAST) begin
                            out_last <= 1'b1;
                            busy     <= 1'b0;
                            state    <= DONE;
                        end else begin
                            out_last <= 1'b0;
                            counter  <= counter + 1'b1;
                        end
                    end else begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                DONE: begin
                    out_valid   <= 1'b0;
                    out_last    <= 1'b0;
                    done        <= 1'b1;
                    decode_fail <= fail_now;
`ifdef RS_CORR_STATS_EN
                    cw_count    <= cw_count + 16'd1;
                    if (fail_now)
                        fail_count <= fail_count + 16'd1;
`endif
                    if (start) begin
                        deg_r <= lambda_deg;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_error_corrector.sv
// Scoreboard bench for rs_error_corrector: a driver pushes expected symbols
// and status derived from whole-codeword arithmetic; a monitor pops on output.

module tb_rs_error_corrector;

    localparam int N = 31;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] lambda_deg = '0;
    logic       hold = 1'b0;
    logic [4:0] sym_in = '0;
    logic       err_loc = 1'b0;
    logic [4:0] err_val = '0;
    logic [4:0] dataout;
    logic       out_valid;
    logic       out_last;
    logic       done;
    logic       decode_fail;
    logic [2:0] err_count;
    logic       busy;
`ifdef RS_CORR_STATS_EN
    logic [15:0] cw_count;
    logic [15:0] fail_count;
`endif

    rs_error_corrector dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .lambda_deg(lambda_deg),
        .hold(hold),
        .sym_in(sym_in),
        .err_loc(err_loc),
        .err_val(err_val),
        .dataout(dataout),
        .out_valid(out_valid),
        .out_last(out_last),
        .done(done),
        .decode_fail(decode_fail),
        .err_count(err_count),
        .busy(busy)
`ifdef RS_CORR_STATS_EN
        ,
        .cw_count(cw_count),
        .fail_count(fail_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [4:0] d;
        logic       l;
    } dexp_t;

    typedef struct {
        logic [2:0] cnt;
        logic       f;
        int         at;
        int         cw;
        int         fc;
    } sexp_t;

    dexp_t dq[$];
    sexp_t sq[$];
    dexp_t me;
    sexp_t ms;

    logic [4:0] cw_sym[N];
    logic [4:0] cw_val[N];
    logic       cw_loc[N];
    int         tot_cw = 0;
    int         tot_fail = 0;
    logic [4:0] last_d;
    logic [2:0] last_cnt;
    logic       last_f;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents something.
    always @(negedge clock) begin
        if (reset) begin
            if (out_valid) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_symbol: got %0d expected none", dataout);
                end else begin
                    me = dq.pop_front();
                    chk("dataout", dataout, me.d);
                    chk("out_last", out_last, me.l);
                end
            end
            if (done) begin
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_done: got 1 expected 0");
                end else begin
                    ms = sq.pop_front();
                    chk("err_count", err_count, ms.cnt);
                    chk("decode_fail", decode_fail, ms.f);
                    chk("done_cycle", cyc, ms.at);
`ifdef RS_CORR_STATS_EN
                    chk("cw_count", cw_count, ms.cw);
                    chk("fail_count", fail_count, ms.fc);
`endif
                end
            end
        end
    end

    task automatic do_start(input logic [2:0] deg, output int t0);
        start      = 1'b1;
        lambda_deg = deg;
        @(posedge clock);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    // Drives one codeword from cw_* arrays; returns in the DONE cycle,
    // or after a reset abort when abort_at >= 0.
    task automatic body(input logic [2:0] deg, input int t0, input int hpos,
                        input int hlen, input bit poke, input int abort_at);
        int cnt;
        bit f;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            dq.push_back('{cw_sym[k] ^ (cw_loc[k] ? cw_val[k] : 5'd0),
                           (k == N - 1)});
            cnt += int'(cw_loc[k]);
        end
        if (cnt > 7) cnt = 7;
        f = (deg > 2) || (cnt != int'(deg));
        if (abort_at < 0) begin
            tot_cw++;
            if (f) tot_fail++;
            sq.push_back('{cnt[2:0], f, t0 + 33 + hlen, tot_cw, tot_fail});
            last_d   = cw_sym[N-1] ^ (cw_loc[N-1] ? cw_val[N-1] : 5'd0);
            last_cnt = cnt[2:0];
            last_f   = f;
        end
        @(posedge clock);
        #1;
        chk("busy_run", busy, 1);
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_dataout", dataout, 0);
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_count", err_count, 0);
                chk("abort_done", done, 0);
                dq.delete();
                tot_cw   = 0;
                tot_fail = 0;
                hold     = 1'b0;
                err_loc  = 1'b0;
                repeat (2) @(posedge clock);
                #1;
                reset = 1'b1;
                return;
            end
            if (k == hpos) begin
                repeat (hlen) begin
                    hold    = 1'b1;
                    err_loc = 1'b1;
                    err_val = 5'($urandom);
                    sym_in  = 5'($urandom);
                    if (poke) begin
                        start      = 1'b1;
                        lambda_deg = 3'd7;
                    end
                    @(posedge clock);
                    #1;
                    start = 1'b0;
                end
            end
            hold    = 1'b0;
            sym_in  = cw_sym[k];
            err_loc = cw_loc[k];
            err_val = cw_val[k];
            @(posedge clock);
            #1;
        end
        err_loc = 1'b0;
        hold    = 1'b0;
    endtask

    task automatic finish_idle();
        @(posedge clock);
        #1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_dataout", dataout, last_d);
        chk("idle_count", err_count, last_cnt);
        chk("idle_fail", decode_fail, last_f);
        chk("idle_busy", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic fill_rand(input int prob);
        for (int k = 0; k < N; k++) begin
            cw_sym[k] = 5'($urandom);
            cw_val[k] = 5'($urandom);
            cw_loc[k] = ($urandom_range(0, 99) < prob);
        end
    endtask

    int t0;
    int t1;
    int nl;

    initial begin
        #1;
        chk("rst_dataout", dataout, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_fail", decode_fail, 0);
        chk("rst_count", err_count, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Clean codeword, err_val noise must be ignored.
        fill_rand(0);
        for (int k = 0; k < N; k++) cw_sym[k] = 5'(k);
        do_start(3'd0, t0);
        body(3'd0, t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Two corrected errors.
        fill_rand(0);
        for (int k = 0; k < N; k++) cw_sym[k] = 5'h0A;
        cw_loc[3]  = 1'b1; cw_val[3]  = 5'h0A;
        cw_loc[17] = 1'b1; cw_val[17] = 5'h0A;
        do_start(3'd2, t0);
        body(3'd2, t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Count mismatch.
        fill_rand(0);
        cw_loc[9] = 1'b1;
        do_start(3'd2, t0);
        body(3'd2, t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Degree above T with matching count.
        fill_rand(0);
        cw_loc[0] = 1'b1; cw_loc[15] = 1'b1; cw_loc[30] = 1'b1;
        do_start(3'd3, t0);
        body(3'd3, t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Stall at symbol 10 with a stray start during CORRECT.
        fill_rand(0);
        cw_loc[10] = 1'b1;
        do_start(3'd1, t0);
        body(3'd1, t0, 10, 4, 1'b1, -1);
        finish_idle();

        // Stall on the last symbol.
        fill_rand(5);
        do_start(3'd1, t0);
        body(3'd1, t0, 30, 2, 1'b0, -1);
        finish_idle();

        // Every symbol flagged: saturation.
        fill_rand(100);
        do_start(3'd2, t0);
        body(3'd2, t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Back-to-back: passing then failing codeword.
        fill_rand(0);
        do_start(3'd0, t0);
        body(3'd0, t0, -1, 0, 1'b0, -1);
        fill_rand(0);
        cw_loc[4] = 1'b1;
        do_start(3'd2, t1);
        chk("b2b_busy", busy, 1);
        body(3'd2, t1, -1, 0, 1'b0, -1);
        finish_idle();

        // Reset abort at symbol 20, then a fresh codeword.
        fill_rand(0);
        do_start(3'd0, t0);
        body(3'd0, t0, -1, 0, 1'b0, 20);
        fill_rand(8);
        nl = 0;
        for (int k = 0; k < N; k++) nl += int'(cw_loc[k]);
        do_start(3'(nl > 7 ? 7 : nl), t0);
        body(3'(nl > 7 ? 7 : nl), t0, -1, 0, 1'b0, -1);
        finish_idle();

        // Randomized codewords.
        for (int i = 0; i < 8; i++) begin
            fill_rand(int'($urandom_range(0, 10)));
            nl = 0;
            for (int k = 0; k < N; k++) nl += int'(cw_loc[k]);
            if ($urandom_range(0, 1) == 1) nl = int'($urandom_range(0, 7));
            if (nl > 7) nl = 7;
            t1 = int'($urandom_range(0, 3));
            do_start(3'(nl), t0);
            body(3'(nl), t0, int'($urandom_range(0, 30)), t1, 1'b0, -1);
            finish_idle();
        end

        chk("sym_queue_empty", dq.size(), 0);
        chk("status_queue_empty", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
